entropy_src_wm_sched: RTL
=========================

// Module: entropy_src_wm_sched
// PURPOSE
//  Schedules updates from NumTests health tests onto one shared watermark-update bus.
//  Each test's window-end result is held in a per-test slot. A round-robin arbiter then
//  issues one (sel, value, event) update per cycle to the bank of high/low watermark
//  registers. Firmware/config clears are also sequenced here; sits between health tests
//  and watermark register bank.
// PARAMETERS
//  NumTests   4    number of requesting health tests (>=2)
//  RegWidth   16   width of test values and watermark registers
//  OvfWidth   8    width of saturating overrun counter
//  SelW       $clog2(NumTests) (localparam) width of wm_sel_o
// PORTS
//  clk_i          in   1                  clock
//  rst_ni         in   1                  reset, asynchronous, active-low
//  enable_i       in   1                  module enable; low flushes all pending work
//  clear_i        in   1                  pulse: clear all watermarks and pending slots
//  win_done_i     in   NumTests           per-test window-end strobe
//  test_val_i     in   NumTests*RegWidth  per-test result; slice i valid with win_done_i[i]
//  wm_event_o     out  1                  registered update strobe to watermark bank
//  wm_sel_o       out  SelW               index of watermark register updated
//  wm_value_o     out  RegWidth           value for the update
//  wm_clear_o     out  NumTests           per-register clear strobe
//  busy_o         out  1                  any slot pending or update in flight
//  overrun_o      out  1                  pulse: a pending result was overwritten
//  overrun_cnt_o  out  OvfWidth           saturating count of overruns
// BEHAVIOUR
//  Reset: all outputs 0; pending_q=0, slots=0, rr_ptr=0, state=IDLE.
//  Capture: win_done_i[i]&enable_i&!clear_i -> slot[i]<=test_val_i[i], pending[i]<=1 next edge.
//  Arbitration:
//   - Combinational grant = first pending index at or after rr_ptr, wrapping NumTests-1 -> 0.
//   - On grant g, next edge: wm_event_o=1, wm_sel_o=g, wm_value_o=slot[g]; pending[g]<=0;
//     rr_ptr<=g+1 (wraps to 0).
//  Throughput/latency:
//   - Max one update per cycle.
//   - Uncontended: win_done at t -> wm_event_o at t+2.
//   - With all NumTests pending, every test is served within NumTests cycles.
//  wm_event_o is a 1-cycle pulse. wm_sel_o/wm_value_o hold their last value when idle.
//  Overrun:
//   - win_done_i[i] while pending[i]=1 and i not granted this cycle -> slot takes the new
//     value (newest wins); overrun_o pulses the next cycle; overrun_cnt_o +1, saturating
//     at all-ones.
//   - win_done_i[i] in the same cycle i is granted: old value issued, new value captured,
//     pending[i] stays 1, no overrun.
//   - Multiple overruns in one cycle: counter +1 only.
//  FSM:
//   - IDLE: no pending. Any pending -> RUN. clear_i -> CLEAR.
//   - RUN: issue grants. Pending becomes 0 after the grant -> IDLE. clear_i -> CLEAR
//     (priority over grant).
//   - CLEAR (one cycle):
//     - wm_clear_o = all ones; wm_event_o = 0.
//     - pending_q, slots, rr_ptr cleared; overrun_cnt_o cleared.
//     - win_done_i ignored.
//     - Next: IDLE.
//  Clearing does not flush the previous cycle's wm_event_o; the bank applies clear over event.
//  enable_i low:
//   - Next edge: pending_q=0, state=IDLE.
//   - No wm_event_o is generated; win_done_i ignored.
//   - clear_i is still honoured.
//   - overrun_cnt_o is retained.
//  busy_o = |pending_q | wm_event_o (registered terms only).
//  Reset mid-operation: asynchronous, returns to reset values immediately; in-flight
//  update lost.
// TESTING
//  - Single: win_done[2], val=0x1234 at t -> wm_event_o@t+2, sel=2, value=0x1234; busy_o
//    low at t+3.
//  - All four done same cycle, rr_ptr=1 -> grants 1,2,3,0 on four consecutive cycles;
//    rr_ptr ends at 1.
//  - Overrun: test0 val=0x10, then test0 val=0x20 while blocked (3 others pending) ->
//    issued value 0x20, overrun_o pulse, overrun_cnt_o=1.
//  - Same-cycle grant/capture: test1 granted while new win_done[1]=0x55 -> 0x?? then 0x55
//    issued; no overrun.
//  - Saturation: 300 overruns with OvfWidth=8 -> overrun_cnt_o=0xFF.
//  - clear_i with 3 pending -> wm_clear_o=4'hF one cycle, no further wm_event_o,
//    overrun_cnt_o=0.
//  - enable_i drop with pending, async reset mid-RUN -> no events, outputs return to 0.

Source files
------------

// File: rtl/entropy_src_wm_sched_if.sv
// rtl/entropy_src_wm_sched_if.sv - health-test result and watermark-update bus
interface entropy_src_wm_sched_if #(
    parameter int NumTests = 4,
    parameter int RegWidth = 16
);
    localparam int SelW = $clog2(NumTests);

    logic [NumTests-1:0]          win_done_i;
    logic [NumTests*RegWidth-1:0] test_val_i;
    logic                         wm_event_o;
    logic [SelW-1:0]              wm_sel_o;
    logic [RegWidth-1:0]          wm_value_o;
    logic [NumTests-1:0]          wm_clear_o;

    modport slave (
        input  win_done_i, test_val_i,
        output wm_event_o, wm_sel_o, wm_value_o, wm_clear_o
    );

    modport master (
        output win_done_i, test_val_i,
        input  wm_event_o, wm_sel_o, wm_value_o, wm_clear_o
    );
endinterface

// File: rtl/entropy_src_wm_sched.sv
// rtl/entropy_src_wm_sched.sv - round-robin scheduler of health-test results onto the watermark bus
module entropy_src_wm_sched #(
    parameter int NumTests = 4,
    parameter int RegWidth = 16,
    parameter int OvfWidth = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      clear_i,
    entropy_src_wm_sched_if.slave     bus,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic [OvfWidth-1:0]       overrun_cnt_o
);
    localparam int SelW = $clog2(NumTests);

    typedef enum logic [1:0] {StIdle, StRun, StClear} state_e;

    state_e                state_q, state_d;
    logic [NumTests-1:0]   pending_q, pending_d;
    logic [RegWidth-1:0]   slot_q [NumTests];
    logic [RegWidth-1:0]   slot_d [NumTests];
    logic [SelW-1:0]       rr_q, rr_d;
    logic [SelW-1:0]       gnt_idx;
    logic                  gnt_found, gnt_vld;
    logic [NumTests-1:0]   ovr;
    logic [OvfWidth-1:0]   cnt_q, cnt_d;
    logic                  overrun_q;
    logic                  wm_event_q;
    logic [SelW-1:0]       wm_sel_q;
    logic [RegWidth-1:0]   wm_value_q;

    // First pending slot at or after the round-robin pointer, wrapping to 0.
    always_comb begin : p_gnt
        int idx;
        logic [SelW-1:0] idx_s;
        idx       = 0;
        idx_s     = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NumTests; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NumTests) idx = idx - NumTests;
            idx_s = SelW'(idx);
            if (!gnt_found && pending_q[idx_s]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_s;
            end
        end
    end

    // Clear takes priority over a grant; no updates are issued while disabled.
    assign gnt_vld = (state_q == StRun) && gnt_found && enable_i && !clear_i;

    // Next-state: clear sequencing, enable flush, grant retire, capture and overrun.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        slot_d    = slot_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        ovr       = '0;
        if (clear_i || state_q == StClear) begin
            pending_d = '0;
            for (int i = 0; i < NumTests; i++) slot_d[i] = '0;
            rr_d    = '0;
            cnt_d   = '0;
            state_d = (state_q == StClear) ? StIdle : StClear;
        end else if (!enable_i) begin
            pending_d = '0;
            state_d   = StIdle;
        end else begin
            if (gnt_vld) begin
                pending_d[gnt_idx] = 1'b0;
                rr_d = (gnt_idx == SelW'(NumTests - 1)) ? '0 : gnt_idx + 1'b1;
            end
            for (int i = 0; i < NumTests; i++) begin
                if (bus.win_done_i[i]) begin
                    // A slot being granted this cycle hands out its old value, so it is not lost.
                    if (pending_q[i] && !(gnt_vld && gnt_idx == SelW'(i))) ovr[i] = 1'b1;
                    slot_d[i]    = bus.test_val_i[i*RegWidth +: RegWidth];
                    pending_d[i] = 1'b1;
                end
            end
            if (|ovr && cnt_q != {OvfWidth{1'b1}}) cnt_d = cnt_q + 1'b1;
            state_d = (|pending_d) ? StRun : StIdle;
        end
    end

    // State, slot and output registers; sel/value hold their last update when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            for (int i = 0; i < NumTests; i++) slot_q[i] <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            wm_event_q <= 1'b0;
            wm_sel_q   <= '0;
            wm_value_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            slot_q     <= slot_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            overrun_q  <= |ovr;
            wm_event_q <= gnt_vld;
            if (gnt_vld) begin
                wm_sel_q   <= gnt_idx;
                wm_value_q <= slot_q[gnt_idx];
            end
        end
    end

    assign bus.wm_event_o = wm_event_q;
    assign bus.wm_sel_o   = wm_sel_q;
    assign bus.wm_value_o = wm_value_q;
    assign bus.wm_clear_o = {NumTests{state_q == StClear}};
    assign busy_o         = (|pending_q) | wm_event_q;
    assign overrun_o      = overrun_q;
    assign overrun_cnt_o  = cnt_q;
endmodule
